mem_bus_arbiter: RTL and testbench

Arbitrates the single synchronous memory port between the CPU core (address/data/read-write driven by the control unit's bus sequencing) and a secondary DMA requester, such as a video or loader engine. The CPU has priority, but a streak limiter guarantees DMA forward progress. A bounded lock mode lets DMA hold the bus for short bursts. The block sits between the core's external bus and the RAM/ROM array, and `cpu_gnt` low doubles as the core's stall condition.

---
 rtl/mem_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA memory port arbiter with DMA streak guarantee and bounded lock
// CPU wins ties until CPU_STREAK_MAX consecutive wins; DMA may then lock the bus for up to DMA_LOCK_MAX grants.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int CPU_STREAK_MAX = 4,
    parameter int DMA_LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_lock,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int SW = $clog2(CPU_STREAK_MAX + 1);
    localparam int LW = $clog2(DMA_LOCK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_STREAK_MAX);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(DMA_LOCK_MAX);

    typedef enum logic {
        ST_ARB        = 1'b0,
        ST_DMA_LOCKED = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_streak;
    logic [SW-1:0] w_streak_nxt;
    logic [LW-1:0] r_lock_cnt;
    logic [LW-1:0] w_lock_nxt;
    logic [LW-1:0] w_lock_inc;
    logic          r_cpu_rv;
    logic          r_dma_rv;
    logic          w_cpu_gnt;
    logic          w_dma_gnt;

    assign w_lock_inc = r_lock_cnt + LW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ARB;
            r_streak   <= '0;
            r_lock_cnt <= '0;
            r_cpu_rv   <= 1'b0;
            r_dma_rv   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_streak   <= w_streak_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_cpu_rv   <= w_cpu_gnt & ~cpu_we;
            r_dma_rv   <= w_dma_gnt & ~dma_we;
        end
    end

    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_dma_gnt    = 1'b0;
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_lock_nxt   = r_lock_cnt;
        if (!reset) begin
            case (r_state)
                ST_ARB: begin
                    if (cpu_req && dma_req) begin
                        w_dma_gnt = (r_streak == STREAK_MAX);
                        w_cpu_gnt = ~w_dma_gnt;
                    end else begin
                        w_cpu_gnt = cpu_req;
                        w_dma_gnt = dma_req;
                    end
                    // streak counts only CPU wins that made DMA wait
                    if (w_dma_gnt || !dma_req) begin
                        w_streak_nxt = '0;
                    end else if (w_cpu_gnt && (r_streak != STREAK_MAX)) begin
                        w_streak_nxt = r_streak + SW'(1);
                    end
                    if (w_dma_gnt && dma_lock && (DMA_LOCK_MAX > 1)) begin
                        w_state_nxt = ST_DMA_LOCKED;
                        w_lock_nxt  = LW'(1);
                    end
                end
                ST_DMA_LOCKED: begin
                    w_dma_gnt = dma_req;
                    if (!dma_req || !dma_lock || (w_lock_inc == LOCK_MAX)) begin
                        w_state_nxt  = ST_ARB;
                        w_lock_nxt   = '0;
                        w_streak_nxt = '0;
                    end else begin
                        w_lock_nxt = w_lock_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_ARB;
                end
            endcase
        end
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign dma_gnt   = w_dma_gnt;
    assign mem_en    = w_cpu_gnt | w_dma_gnt;
    assign mem_we    = (w_cpu_gnt & cpu_we) | (w_dma_gnt & dma_we);
    assign mem_addr  = w_cpu_gnt ? cpu_addr  : (w_dma_gnt ? dma_addr  : '0);
    assign mem_wdata = w_cpu_gnt ? cpu_wdata : (w_dma_gnt ? dma_wdata : '0);
    // a read granted just before reset must not report valid while reset is held
    assign cpu_rvalid = r_cpu_rv & ~reset;
    assign dma_rvalid = r_dma_rv & ~reset;
    assign rdata      = mem_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int SMAX = 4;
    localparam int LMAX = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b1, cpu_we = 1'b0, dma_req = 1'b1, dma_we = 1'b0, dma_lock = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_STREAK_MAX(SMAX), .DMA_LOCK_MAX(LMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata)
    );

    // memory device: unwritten locations read as (addr ^ 0x91)
    logic [DW-1:0] dev_mem [256];
    bit            dev_wr  [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                dev_mem[mem_addr[7:0]] <= mem_wdata;
                dev_wr[mem_addr[7:0]]  <= 1'b1;
            end else begin
                mem_rdata <= dev_wr[mem_addr[7:0]] ? dev_mem[mem_addr[7:0]] : (mem_addr[7:0] ^ 8'h91);
            end
        end
    end

    // reference model
    logic [DW-1:0] ref_mem [256];
    int            m_streak = 0, m_lock_cnt = 0;
    bit            m_locked = 0, m_cpu_rv = 0, m_dma_rv = 0;
    logic [DW-1:0] m_rdata = '0;

    function automatic void model_grant(output bit c, output bit d);
        c = 0;
        d = 0;
        if (reset) return;
        if (m_locked) begin
            d = dma_req;
        end else if (cpu_req && dma_req) begin
            d = (m_streak >= SMAX);
            c = !d;
        end else begin
            c = cpu_req;
            d = dma_req;
        end
    endfunction

    task automatic model_commit();
        bit c, d;
        model_grant(c, d);
        if (reset) begin
            m_streak = 0; m_lock_cnt = 0; m_locked = 0; m_cpu_rv = 0; m_dma_rv = 0;
            return;
        end
        m_cpu_rv = c && !cpu_we;
        m_dma_rv = d && !dma_we;
        if (c) begin
            if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
            else        m_rdata = ref_mem[cpu_addr[7:0]];
        end
        if (d) begin
            if (dma_we) ref_mem[dma_addr[7:0]] = dma_wdata;
            else        m_rdata = ref_mem[dma_addr[7:0]];
        end
        if (m_locked) begin
            if (!dma_req || !dma_lock || (m_lock_cnt + 1 == LMAX)) begin
                m_locked = 0; m_lock_cnt = 0; m_streak = 0;
            end else begin
                m_lock_cnt++;
            end
        end else begin
            if (d || !dma_req) m_streak = 0;
            else if (c && m_streak < SMAX) m_streak++;
            if (d && dma_lock && LMAX > 1) begin
                m_locked = 1; m_lock_cnt = 1;
            end
        end
    endtask

    task automatic step();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; dma_req = 0; dma_lock = 0; reset = 0;
        step();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got=%b exp=0", cpu_gnt); end
            checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt got=%b exp=0", dma_gnt); end
            checks++; if (mem_en !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem got en=%b addr=%h exp 0", mem_en, mem_addr); end
            checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", cpu_rvalid, dma_rvalid); end
            step();
        end
        idle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; dma_req = 0;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL cpu_read_gnt got=%b exp=1", cpu_gnt); end
        checks++; if (mem_addr !== 16'h1234 || mem_we !== 1'b0 || mem_en !== 1'b1) begin errors++; $display("FAIL cpu_read_mem got addr=%h we=%b en=%b exp 1234/0/1", mem_addr, mem_we, mem_en); end
        step();
        cpu_req = 0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_read_rvalid got c=%b d=%b exp c=1 d=0", cpu_rvalid, dma_rvalid); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL cpu_read_rdata got=%h exp=a5", rdata); end
        step();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h3C; dma_req = 0;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL cpu_write_strobe got en=%b we=%b exp 1/1", mem_en, mem_we); end
        checks++; if (mem_addr !== 16'h0200 || mem_wdata !== 8'h3C) begin errors++; $display("FAIL cpu_write_bus got addr=%h wdata=%h exp 0200/3c", mem_addr, mem_wdata); end
        step();
        cpu_req = 0; cpu_we = 0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_write_no_rvalid got=%b%b exp=00", cpu_rvalid, dma_rvalid); end
        step();
    endtask

    task automatic test_streak();
        idle();
        cpu_req = 1; cpu_we = 0; dma_req = 1; dma_we = 0; dma_lock = 0;
        for (int i = 0; i < 15; i++) begin
            bit exp_d;
            exp_d = ((i % (SMAX + 1)) == SMAX);
            @(negedge clk);
            checks++;
            if (dma_gnt !== exp_d || cpu_gnt !== !exp_d) begin
                errors++; $display("FAIL streak_cycle%0d got c=%b d=%b exp c=%b d=%b", i, cpu_gnt, dma_gnt, !exp_d, exp_d);
            end
            step();
        end
    endtask

    task automatic test_lock_limit();
        string exp = "CCCCDDDDDDDDCCCCDDDD.C";
        int    dgr = 0;
        byte   ch;
        idle();
        for (int i = 0; i < exp.len(); i++) begin
            cpu_req = 1; cpu_we = 0; dma_lock = 1; dma_we = 0;
            dma_req = (dgr < 12);
            ch = exp.getc(i);
            @(negedge clk);
            checks++;
            if (cpu_gnt !== (ch == "C") || dma_gnt !== (ch == "D")) begin
                errors++; $display("FAIL lock_limit_cycle%0d got c=%b d=%b exp %c", i, cpu_gnt, dma_gnt, ch);
            end
            if (ch == "D") dgr++;
            step();
        end
    endtask

    task automatic test_early_release();
        bit    cp [2][4] = '{'{0, 1, 1, 1}, '{0, 1, 1, 1}};
        bit    dp [2][4] = '{'{1, 1, 1, 1}, '{1, 1, 0, 0}};
        bit    lp [2][4] = '{'{1, 1, 0, 1}, '{1, 1, 1, 1}};
        string ex [2]    = '{"DDDC", "DD.C"};
        byte   ch;
        for (int s = 0; s < 2; s++) begin
            idle();
            for (int i = 0; i < 4; i++) begin
                cpu_req = cp[s][i]; dma_req = dp[s][i]; dma_lock = lp[s][i];
                ch = ex[s].getc(i);
                @(negedge clk);
                checks++;
                if (cpu_gnt !== (ch == "C") || dma_gnt !== (ch == "D")) begin
                    errors++; $display("FAIL early_release_s%0d_c%0d got c=%b d=%b exp %c", s, i, cpu_gnt, dma_gnt, ch);
                end
                step();
            end
        end
    endtask

    task automatic test_reset_midlock();
        idle();
        cpu_req = 0; dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 16'h0010;
        @(negedge clk);
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL midlock_first got=%b exp=1", dma_gnt); end
        step();
        cpu_req = 1;
        @(negedge clk);
        checks++; if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL midlock_locked got c=%b d=%b exp c=0 d=1", cpu_gnt, dma_gnt); end
        step();
        reset = 1;
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL midlock_rvalid got=%b exp=0", dma_rvalid); end
        checks++; if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL midlock_reset_gnt got c=%b d=%b en=%b exp 0", cpu_gnt, dma_gnt, mem_en); end
        step();
        reset = 0;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL midlock_after got c=%b d=%b exp c=1 d=0", cpu_gnt, dma_gnt); end
        step();
    endtask

    task automatic test_random();
        bit            c, d;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        idle();
        for (int n = 0; n < 800; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            dma_lock = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_grant(c, d);
            ea = c ? cpu_addr  : (d ? dma_addr  : '0);
            ew = c ? cpu_wdata : (d ? dma_wdata : '0);
            checks++; if (cpu_gnt !== c || dma_gnt !== d) begin errors++; $display("FAIL rnd_gnt n=%0d got c=%b d=%b exp c=%b d=%b", n, cpu_gnt, dma_gnt, c, d); end
            checks++; if (mem_en !== (c | d) || mem_we !== ((c & cpu_we) | (d & dma_we))) begin errors++; $display("FAIL rnd_strobe n=%0d got en=%b we=%b", n, mem_en, mem_we); end
            checks++; if (mem_addr !== ea || mem_wdata !== ew) begin errors++; $display("FAIL rnd_bus n=%0d got %h/%h exp %h/%h", n, mem_addr, mem_wdata, ea, ew); end
            checks++; if (cpu_rvalid !== (m_cpu_rv && !reset) || dma_rvalid !== (m_dma_rv && !reset)) begin errors++; $display("FAIL rnd_rvalid n=%0d got c=%b d=%b exp c=%b d=%b", n, cpu_rvalid, dma_rvalid, m_cpu_rv && !reset, m_dma_rv && !reset); end
            if ((m_cpu_rv || m_dma_rv) && !reset) begin
                checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata, m_rdata); end
            end
            step();
            if (c || !cpu_req) begin
                cpu_req = ($urandom_range(0, 3) != 0); cpu_we = $urandom_range(0, 1);
                cpu_addr = {8'($urandom), 4'h0, 4'($urandom)}; cpu_wdata = 8'($urandom);
            end
            if (d || !dma_req) begin
                dma_req = $urandom_range(0, 1); dma_we = $urandom_range(0, 1);
                dma_addr = {8'($urandom), 4'h0, 4'($urandom)}; dma_wdata = 8'($urandom);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h91;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_streak();
        test_lock_limit();
        test_early_release();
        test_reset_midlock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
